vc_pop_scheduler: RTL

// - Weighted-priority pop scheduler between the VC0 and VC1 input FIFOs and the D0/D1 destination FIFOs.
// - VC0 normally wins. VC1 is guaranteed one grant after every VC0_WEIGHT consecutive VC0 grants made while VC1 was waiting.
// - Each popped word is routed to D0 or D1 by its destination bit.
// - The block issues at most one pop per cycle and carries the 2-cycle pop->push pipeline.

---
 rtl/vc_pop_scheduler.sv | 101 ++++++++++
 1 files changed

// File: rtl/vc_pop_scheduler.sv
// rtl/vc_pop_scheduler.sv - weighted VC0/VC1 pop scheduler with a 2-cycle pop->push pipeline
module vc_pop_scheduler #(
    parameter int DATA_W     = 6,
    parameter int VC0_WEIGHT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_afull,
    input  logic              d1_afull,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] d_data,
    output logic              vc1_starved
);

    typedef enum logic {
        PRI_VC0 = 1'b0,
        PRI_VC1 = 1'b1
    } state_t;

    localparam logic [3:0] WCNT_LAST = 4'(VC0_WEIGHT - 1);

    state_t      state, state_d;
    logic [3:0]  wcnt, wcnt_d;
    logic        elig;
    logic        vld_q;
    logic        sel_q;
    logic [DATA_W-1:0] word;

    // Both destinations must have room since the word's destination is unknown until it is read.
    assign elig = !d0_afull && !d1_afull && !reset;

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        vc0_pop = 1'b0;
        vc1_pop = 1'b0;
        if (elig) begin
            if (state == PRI_VC0) begin
                if (!vc0_empty) begin
                    vc0_pop = 1'b1;
                    if (!vc1_empty) begin
                        if (wcnt == WCNT_LAST) begin
                            state_d = PRI_VC1;
                            wcnt_d  = 4'd0;
                        end else begin
                            wcnt_d = wcnt + 4'd1;
                        end
                    end
                end else if (!vc1_empty) begin
                    vc1_pop = 1'b1;
                    wcnt_d  = 4'd0;
                end
            end else begin
                // VC1's owed turn is consumed by any grant, even a fallback to VC0.
                if (!vc1_empty) begin
                    vc1_pop = 1'b1;
                    state_d = PRI_VC0;
                    wcnt_d  = 4'd0;
                end else if (!vc0_empty) begin
                    vc0_pop = 1'b1;
                    state_d = PRI_VC0;
                    wcnt_d  = 4'd0;
                end
            end
        end
    end

    assign word = sel_q ? vc1_data : vc0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PRI_VC0;
            wcnt        <= 4'd0;
            vld_q       <= 1'b0;
            sel_q       <= 1'b0;
            d0_push     <= 1'b0;
            d1_push     <= 1'b0;
            d_data      <= '0;
            vc1_starved <= 1'b0;
        end else begin
            state       <= state_d;
            wcnt        <= wcnt_d;
            vld_q       <= vc0_pop || vc1_pop;
            sel_q       <= vc1_pop;
            d0_push     <= vld_q && !word[DATA_W-1];
            d1_push     <= vld_q && word[DATA_W-1];
            if (vld_q) begin
                d_data <= word;
            end
            vc1_starved <= (state_d == PRI_VC1) && !vc1_empty;
        end
    end

endmodule
